// File: rtl/fifo_rd_port.sv
// fifo_rd_port: read side of the FIFO, drains 1-cycle-latency storage into a 2-entry valid/ready buffer.
// Define FIFO_RD_LEVEL_EN to add the combinational LEVEL occupancy output.
module fifo_rd_port #(
  parameter int DEPTH_LOG2 = 4,
  parameter int WIDTH      = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [DEPTH_LOG2:0]   wr_ptr,
  output logic [DEPTH_LOG2:0]   rd_ptr,
  output logic                  mem_re,
  output logic [DEPTH_LOG2-1:0] mem_raddr,
  input  logic [WIDTH-1:0]      mem_rdata,
  output logic [WIDTH-1:0]      out_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  empty
`ifdef FIFO_RD_LEVEL_EN
  ,
  output logic [DEPTH_LOG2+1:0] level
`endif
);

  typedef enum logic [1:0] {B0, B1, B2} buf_state_t;

  buf_state_t       state, state_next;
  logic             inflight;
  logic             mem_empty;
  logic             pop;
  logic [1:0]       cnt;
  logic [2:0]       occupancy;
  logic [WIDTH-1:0] head, tail;
  logic             head_from_rdata, head_from_tail, tail_from_rdata;

  assign mem_empty = (rd_ptr == wr_ptr);
  assign out_valid = (state != B0);
  assign out_data  = head;
  assign pop       = out_valid & out_ready;
  assign mem_raddr = rd_ptr[DEPTH_LOG2-1:0];

  // Fetch only while the word still in flight is guaranteed a buffer slot.
  assign occupancy = {1'b0, cnt} + {2'b00, inflight} - {2'b00, pop};
  assign mem_re    = rst_n & ~mem_empty & (occupancy < 3'd2);
  assign empty     = ~rst_n | (mem_empty & ~inflight & (state == B0));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= B0;
    else        state <= state_next;
  end

  // Buffer occupancy FSM; a push with cnt=2 cannot occur because of the issue rule.
  always_comb begin
    state_next      = state;
    cnt             = 2'd0;
    head_from_rdata = 1'b0;
    head_from_tail  = 1'b0;
    tail_from_rdata = 1'b0;
    case (state)
      B0: begin
        cnt = 2'd0;
        if (inflight) begin
          head_from_rdata = 1'b1;
          state_next      = B1;
        end
      end
      B1: begin
        cnt = 2'd1;
        if (inflight && pop) begin
          head_from_rdata = 1'b1;
        end else if (inflight) begin
          tail_from_rdata = 1'b1;
          state_next      = B2;
        end else if (pop) begin
          state_next = B0;
        end
      end
      B2: begin
        cnt = 2'd2;
        if (pop) begin
          head_from_tail = 1'b1;
          if (inflight) tail_from_rdata = 1'b1;
          else          state_next      = B1;
        end
      end
      default: state_next = B0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr   <= '0;
      inflight <= 1'b0;
      head     <= '0;
      tail     <= '0;
    end else begin
      if (mem_re) rd_ptr <= rd_ptr + {{DEPTH_LOG2{1'b0}}, 1'b1};
      inflight <= mem_re;
      if (head_from_rdata)     head <= mem_rdata;
      else if (head_from_tail) head <= tail;
      if (tail_from_rdata)     tail <= mem_rdata;
    end
  end

`ifdef FIFO_RD_LEVEL_EN
  logic [DEPTH_LOG2:0] ptr_diff;
  assign ptr_diff = wr_ptr - rd_ptr;
  assign level = rst_n ? ({1'b0, ptr_diff} + {{(DEPTH_LOG2+1){1'b0}}, inflight}
                          + {{DEPTH_LOG2{1'b0}}, cnt})
                       : '0;
`endif

endmodule

// File: tb/tb_fifo_rd_port.sv
// tb_fifo_rd_port: directed bench for fifo_rd_port with a 1-cycle-latency storage model.
// Define FIFO_RD_LEVEL_EN to also check the LEVEL output.
module tb_fifo_rd_port;

  logic       clk;
  logic       rst_n;
  logic [4:0] wr_ptr;
  logic [4:0] rd_ptr;
  logic       mem_re;
  logic [3:0] mem_raddr;
  logic [7:0] mem_rdata;
  logic [7:0] out_data;
  logic       out_valid;
  logic       out_ready;
  logic       empty;
`ifdef FIFO_RD_LEVEL_EN
  logic [5:0] level;
`endif

  logic [7:0] mem [16];
  int compared   = 0;
  int mismatched = 0;

  fifo_rd_port #(.DEPTH_LOG2(4), .WIDTH(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .wr_ptr    (wr_ptr),
    .rd_ptr    (rd_ptr),
    .mem_re    (mem_re),
    .mem_raddr (mem_raddr),
    .mem_rdata (mem_rdata),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .empty     (empty)
`ifdef FIFO_RD_LEVEL_EN
    ,
    .level     (level)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Storage RAM: one cycle of read latency.
  always @(posedge clk) if (mem_re) mem_rdata <= mem[mem_raddr];

  task automatic do_reset;
    @(negedge clk);
    rst_n = 1'b0; out_ready = 1'b0; wr_ptr = 5'd0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_reset;
    rst_n = 1'b0; wr_ptr = 5'd5; out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      compared += 4;
      if (rd_ptr !== 5'd0) begin mismatched++; $display("[TB] FAIL reset_rd_ptr got %0d want 0", rd_ptr); end
      if (out_valid !== 1'b0) begin mismatched++; $display("[TB] FAIL reset_valid got %b want 0", out_valid); end
      if (empty !== 1'b1) begin mismatched++; $display("[TB] FAIL reset_empty got %b want 1", empty); end
      if (mem_re !== 1'b0) begin mismatched++; $display("[TB] FAIL reset_mem_re got %b want 0", mem_re); end
`ifdef FIFO_RD_LEVEL_EN
      compared++;
      if (level !== 6'd0) begin mismatched++; $display("[TB] FAIL reset_level got %0d want 0", level); end
`endif
    end
    wr_ptr = 5'd0; rst_n = 1'b1;
    @(negedge clk);
    compared += 2;
    if (empty !== 1'b1) begin mismatched++; $display("[TB] FAIL release_empty got %b want 1", empty); end
    if (rd_ptr !== 5'd0) begin mismatched++; $display("[TB] FAIL release_rd_ptr got %0d want 0", rd_ptr); end
  endtask

  task automatic test_single_word;
    out_ready = 1'b1; wr_ptr = 5'd1;
    #1;
    compared += 2;
    if (mem_re !== 1'b1) begin mismatched++; $display("[TB] FAIL single_mem_re got %b want 1", mem_re); end
    if (mem_raddr !== 4'd0) begin mismatched++; $display("[TB] FAIL single_raddr got %0d want 0", mem_raddr); end
    @(negedge clk);
    compared += 2;
    if (out_valid !== 1'b0) begin mismatched++; $display("[TB] FAIL single_early_valid got %b want 0", out_valid); end
    if (mem_re !== 1'b0) begin mismatched++; $display("[TB] FAIL single_refetch got %b want 0", mem_re); end
    @(negedge clk);
    compared += 2;
    if (out_valid !== 1'b1) begin mismatched++; $display("[TB] FAIL single_valid got %b want 1", out_valid); end
    if (out_data !== 8'h80) begin mismatched++; $display("[TB] FAIL single_data got %h want 80", out_data); end
    @(negedge clk);
    compared += 2;
    if (out_valid !== 1'b0) begin mismatched++; $display("[TB] FAIL single_post_valid got %b want 0", out_valid); end
    if (empty !== 1'b1) begin mismatched++; $display("[TB] FAIL single_post_empty got %b want 1", empty); end
  endtask

  task automatic test_streaming;
    int seen;
    int gaps;
    bit started;
    logic [7:0] exp_data;
    seen = 0; gaps = 0; started = 1'b0;
    do_reset();
    out_ready = 1'b1; wr_ptr = 5'd16;
`ifdef FIFO_RD_LEVEL_EN
    #1;
    compared++;
    if (level !== 6'd16) begin mismatched++; $display("[TB] FAIL stream_level_start got %0d want 16", level); end
`endif
    for (int cyc = 0; cyc < 40 && seen < 16; cyc++) begin
      @(negedge clk);
`ifdef FIFO_RD_LEVEL_EN
      compared++;
      if (level !== 6'(16 - seen)) begin
        mismatched++; $display("[TB] FAIL stream_level got %0d want %0d", level, 16 - seen);
      end
`endif
      if (out_valid) begin
        exp_data = 8'h80 + 8'(seen);
        compared++;
        if (out_data !== exp_data) begin
          mismatched++; $display("[TB] FAIL stream_data[%0d] got %h want %h", seen, out_data, exp_data);
        end
        seen++; started = 1'b1;
      end else if (started) begin
        gaps++;
      end
    end
    @(negedge clk);
    compared += 5;
    if (seen !== 16) begin mismatched++; $display("[TB] FAIL stream_count got %0d want 16", seen); end
    if (gaps !== 0) begin mismatched++; $display("[TB] FAIL stream_bubbles got %0d want 0", gaps); end
    if (rd_ptr !== 5'd16) begin mismatched++; $display("[TB] FAIL stream_rd_ptr got %0d want 16", rd_ptr); end
    if (empty !== 1'b1) begin mismatched++; $display("[TB] FAIL stream_empty got %b want 1", empty); end
    if (out_valid !== 1'b0) begin mismatched++; $display("[TB] FAIL stream_end_valid got %b want 0", out_valid); end
`ifdef FIFO_RD_LEVEL_EN
    compared++;
    if (level !== 6'd0) begin mismatched++; $display("[TB] FAIL stream_level_end got %0d want 0", level); end
`endif
  endtask

  task automatic test_backpressure;
    int pulses;
    int n;
    logic [7:0] exp_data;
    pulses = 0; n = 0;
    do_reset();
    wr_ptr = 5'd3;
    #1;
    if (mem_re) pulses++;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (mem_re) pulses++;
    end
    compared += 4;
    if (pulses !== 2) begin mismatched++; $display("[TB] FAIL bp_pulses got %0d want 2", pulses); end
    if (out_valid !== 1'b1) begin mismatched++; $display("[TB] FAIL bp_valid got %b want 1", out_valid); end
    if (out_data !== 8'h80) begin mismatched++; $display("[TB] FAIL bp_hold_data got %h want 80", out_data); end
    if (rd_ptr !== 5'd2) begin mismatched++; $display("[TB] FAIL bp_rd_ptr got %0d want 2", rd_ptr); end
    out_ready = 1'b1;
    #1;
    for (int cyc = 0; cyc < 8; cyc++) begin
      if (out_valid) begin
        exp_data = 8'h80 + 8'(n);
        compared++;
        if (out_data !== exp_data) begin
          mismatched++; $display("[TB] FAIL bp_data[%0d] got %h want %h", n, out_data, exp_data);
        end
        n++;
      end
      @(negedge clk);
    end
    compared += 2;
    if (n !== 3) begin mismatched++; $display("[TB] FAIL bp_count got %0d want 3", n); end
    if (empty !== 1'b1) begin mismatched++; $display("[TB] FAIL bp_empty got %b want 1", empty); end
  endtask

  task automatic test_wrap;
    int exp_addr [4] = '{14, 15, 0, 1};
    logic [7:0] exp_word [4] = '{8'h8E, 8'h8F, 8'h80, 8'h81};
    int na;
    int nd;
    bit drained;
    na = 0; nd = 0; drained = 1'b0;
    do_reset();
    out_ready = 1'b1; wr_ptr = 5'd30;
    for (int cyc = 0; cyc < 80 && !drained; cyc++) begin
      @(negedge clk);
      if (empty) drained = 1'b1;
    end
    compared += 2;
    if (drained !== 1'b1) begin mismatched++; $display("[TB] FAIL wrap_drain_timeout got %b want 1", drained); end
    if (rd_ptr !== 5'd30) begin mismatched++; $display("[TB] FAIL wrap_pre_rd_ptr got %0d want 30", rd_ptr); end
    wr_ptr = 5'd2;
    #1;
    for (int cyc = 0; cyc < 10; cyc++) begin
      if (mem_re) begin
        if (na < 4) begin
          compared++;
          if (mem_raddr !== 4'(exp_addr[na])) begin
            mismatched++; $display("[TB] FAIL wrap_raddr[%0d] got %0d want %0d", na, mem_raddr, exp_addr[na]);
          end
        end
        na++;
      end
      if (out_valid) begin
        if (nd < 4) begin
          compared++;
          if (out_data !== exp_word[nd]) begin
            mismatched++; $display("[TB] FAIL wrap_data[%0d] got %h want %h", nd, out_data, exp_word[nd]);
          end
        end
        nd++;
      end
      @(negedge clk);
    end
    compared += 4;
    if (na !== 4) begin mismatched++; $display("[TB] FAIL wrap_fetches got %0d want 4", na); end
    if (nd !== 4) begin mismatched++; $display("[TB] FAIL wrap_words got %0d want 4", nd); end
    if (rd_ptr !== 5'd2) begin mismatched++; $display("[TB] FAIL wrap_rd_ptr got %0d want 2", rd_ptr); end
    if (empty !== 1'b1) begin mismatched++; $display("[TB] FAIL wrap_empty got %b want 1", empty); end
  endtask

  task automatic test_reset_mid_burst;
    do_reset();
    wr_ptr = 5'd3;
    @(negedge clk);
    @(negedge clk);
    compared++;
    if (out_valid !== 1'b1) begin mismatched++; $display("[TB] FAIL mid_pre_valid got %b want 1", out_valid); end
    rst_n = 1'b0;
    #1;
    compared += 4;
    if (out_valid !== 1'b0) begin mismatched++; $display("[TB] FAIL mid_valid got %b want 0", out_valid); end
    if (mem_re !== 1'b0) begin mismatched++; $display("[TB] FAIL mid_mem_re got %b want 0", mem_re); end
    if (empty !== 1'b1) begin mismatched++; $display("[TB] FAIL mid_empty got %b want 1", empty); end
    if (rd_ptr !== 5'd0) begin mismatched++; $display("[TB] FAIL mid_rd_ptr got %0d want 0", rd_ptr); end
    @(negedge clk);
    wr_ptr = 5'd0; rst_n = 1'b1;
    @(negedge clk);
    @(negedge clk);
    compared += 2;
    if (empty !== 1'b1) begin mismatched++; $display("[TB] FAIL mid_post_empty got %b want 1", empty); end
    if (out_valid !== 1'b0) begin mismatched++; $display("[TB] FAIL mid_post_valid got %b want 0", out_valid); end
  endtask

  initial begin
    for (int i = 0; i < 16; i++) mem[i] = 8'h80 + 8'(i);
    mem_rdata = 8'h00;
    rst_n = 1'b0; wr_ptr = 5'd5; out_ready = 1'b0;
    test_reset();
    test_single_word();
    test_streaming();
    test_backpressure();
    test_wrap();
    test_reset_mid_burst();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
